// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Used by mem_port_arbiter and by anything that drives its mode field.
package mem_port_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  // Access-mode encoding shared with the memory controller
  localparam logic [2:0] MODE_BYTE   = 3'b000;
  localparam logic [2:0] MODE_HALF   = 3'b001;
  localparam logic [2:0] MODE_WORD   = 3'b010;
  localparam logic [2:0] MODE_BYTE_U = 3'b100;
  localparam logic [2:0] MODE_HALF_U = 3'b101;

  // True while an access is outstanding on the memory port
  function automatic logic is_busy(arb_state_t s);
    return (s == BUSY_IF) || (s == BUSY_D);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the arbiter.
// slave  : the arbiter's view.
// master : the surrounding core/memory view (fetch path, data path, memory).
interface mem_port_arbiter_if #(
  parameter int Width = 32
);
  logic             if_req;
  logic [Width-1:0] if_addr;
  logic             if_valid;
  logic [Width-1:0] if_rdata;

  logic             d_req;
  logic             d_we;
  logic [Width-1:0] d_addr;
  logic [Width-1:0] d_wdata;
  logic [2:0]       d_mode;
  logic             d_valid;
  logic [Width-1:0] d_rdata;

  logic             mem_req;
  logic             mem_we;
  logic [Width-1:0] mem_addr;
  logic [Width-1:0] mem_wdata;
  logic [2:0]       mem_mode;
  logic             mem_ready;
  logic [Width-1:0] mem_rdata;

  logic             stall;
  logic             err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_mode,
    input  mem_ready, mem_rdata,
    output if_valid, if_rdata, d_valid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_mode,
    output stall, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_mode,
    output mem_ready, mem_rdata,
    input  if_valid, if_rdata, d_valid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_mode,
    input  stall, err
  );

endinterface

// File: rtl/mem_port_arbiter_timeout_counter.sv
// Busy-cycle counter for the arbiter's memory timeout.
// Only instantiated when MEM_PORT_ARB_TIMEOUT_EN is defined.
// expired_o is high once TIMEOUT-1 busy cycles without mem_ready have elapsed.
module arb_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  assign expired_o = (count_q == LAST);

  // Clear on grant, count waiting cycles, saturate at the terminal value
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single unified memory port.
// Data accesses have fixed priority over instruction fetch. The granted
// request is latched so requesters may change inputs after the grant.
// Optional busy timeout: define MEM_PORT_ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no access outstanding; grant on d_req, else if_req
// BUSY_IF | fetch on the memory port, waiting for mem_ready
// BUSY_D  | load/store on the memory port, waiting for mem_ready
// RESP    | one-cycle valid pulse to the served requester
module mem_port_arbiter
  import mem_port_pkg::*;
#(
  parameter int Width   = 32,
  parameter int TIMEOUT = 16
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  arb_state_t       state_q, state_d;
  logic [Width-1:0] addr_q, addr_d;
  logic [Width-1:0] wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [2:0]       mode_q, mode_d;
  logic             sel_data_q, sel_data_d;
  logic [Width-1:0] if_rdata_q, if_rdata_d;
  logic [Width-1:0] d_rdata_q, d_rdata_d;
  logic             busy;
  logic             expired;

  assign busy = is_busy(state_q);

`ifdef MEM_PORT_ARB_TIMEOUT_EN
  logic grant;
  logic err_q;

  assign grant = (state_q == IDLE) && (bus.d_req || bus.if_req);

  arb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (grant),
    .enable_i  (busy && !bus.mem_ready),
    .expired_o (expired)
  );

  // err pulses alongside the valid of an access that was abandoned
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= busy && !bus.mem_ready && expired;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT > 0);
  assign expired        = 1'b0;
  assign bus.err        = 1'b0;
`endif

  // Next-state and datapath-capture logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    mode_d     = mode_q;
    sel_data_d = sel_data_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.d_req) begin
          state_d    = BUSY_D;
          sel_data_d = 1'b1;
          addr_d     = bus.d_addr;
          wdata_d    = bus.d_wdata;
          we_d       = bus.d_we;
          mode_d     = bus.d_mode;
        end else if (bus.if_req) begin
          state_d    = BUSY_IF;
          sel_data_d = 1'b0;
          addr_d     = bus.if_addr;
          wdata_d    = '0;
          we_d       = 1'b0;
          mode_d     = MODE_WORD;
        end
      end

      BUSY_IF, BUSY_D: begin
        if (bus.mem_ready) begin
          state_d = RESP;
          if (!sel_data_q) begin
            if_rdata_d = bus.mem_rdata;
          end else if (!we_q) begin
            d_rdata_d = bus.mem_rdata;
          end
        end else if (expired) begin
          // abandoned access returns zero data
          state_d = RESP;
          if (!sel_data_q) begin
            if_rdata_d = '0;
          end else if (!we_q) begin
            d_rdata_d = '0;
          end
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched-request registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      mode_q     <= 3'b000;
      sel_data_q <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      mode_q     <= mode_d;
      sel_data_q <= sel_data_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.mem_req   = busy;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_mode  = mode_q;

  assign bus.if_valid  = (state_q == RESP) && !sel_data_q;
  assign bus.d_valid   = (state_q == RESP) &&  sel_data_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

  // stall is forced low during reset so the core sees all outputs at zero
  assign bus.stall = !reset &&
                     (busy || ((state_q == IDLE) && (bus.if_req || bus.d_req)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Inputs change and outputs are sampled 1 time unit after the falling edge.
module tb_mem_port_arbiter;
  import mem_port_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.Width(32)) bus();

  mem_port_arbiter #(.Width(32), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference: rdata registers hold until overwritten by a load/fetch
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_d_rdata  = '0;

  logic [2:0] modes [5] = '{MODE_BYTE, MODE_HALF, MODE_WORD, MODE_BYTE_U, MODE_HALF_U};

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    bus.mem_ready = 1'($urandom);
    bus.mem_rdata = $urandom;
  endtask

  // Entered 1 unit into an IDLE cycle with the request(s) already asserted.
  // Checks the grant cycle, every busy cycle and the response cycle.
  task automatic serve(input bit is_d, input logic [31:0] addr, input bit we,
                       input logic [31:0] wdata, input logic [2:0] mode,
                       input int lat, input logic [31:0] rdata, input bit keep_req);
    chk1 ("idle_stall",    bus.stall,    1'b1);
    chk1 ("idle_mem_req",  bus.mem_req,  1'b0);
    chk1 ("idle_if_valid", bus.if_valid, 1'b0);
    chk1 ("idle_d_valid",  bus.d_valid,  1'b0);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      bus.mem_ready = (i == lat);
      bus.mem_rdata = (i == lat) ? rdata : $urandom;
      if (is_d) begin
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
        bus.d_we    = 1'($urandom);
        bus.d_mode  = 3'($urandom);
      end else begin
        bus.if_addr = $urandom;
      end
      #1;
      chk1 ("busy_mem_req", bus.mem_req, 1'b1);
      chk32("busy_addr",    bus.mem_addr, addr);
      chk1 ("busy_we",      bus.mem_we, is_d ? we : 1'b0);
      chk32("busy_mode",    {29'd0, bus.mem_mode}, {29'd0, is_d ? mode : MODE_WORD});
      if (is_d) chk32("busy_wdata", bus.mem_wdata, wdata);
      chk1 ("busy_stall",   bus.stall, 1'b1);
      chk1 ("busy_valid",   bus.if_valid | bus.d_valid, 1'b0);
    end
    @(negedge clk);
    bus.mem_ready = 1'($urandom);
    bus.mem_rdata = $urandom;
    if (!keep_req) begin
      if (is_d) bus.d_req = 1'b0;
      else      bus.if_req = 1'b0;
    end
    #1;
    if (!is_d)    m_if_rdata = rdata;
    else if (!we) m_d_rdata  = rdata;
    chk1 ("resp_if_valid", bus.if_valid, !is_d);
    chk1 ("resp_d_valid",  bus.d_valid,  is_d);
    chk32("resp_if_rdata", bus.if_rdata, m_if_rdata);
    chk32("resp_d_rdata",  bus.d_rdata,  m_d_rdata);
    chk1 ("resp_stall",    bus.stall,    1'b0);
    chk1 ("resp_mem_req",  bus.mem_req,  1'b0);
    chk1 ("resp_err",      bus.err,      1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_mode = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk1 ("rst_mem_req",  bus.mem_req,  1'b0);
    chk1 ("rst_stall",    bus.stall,    1'b0);
    chk1 ("rst_if_valid", bus.if_valid, 1'b0);
    chk1 ("rst_d_valid",  bus.d_valid,  1'b0);
    chk32("rst_if_rdata", bus.if_rdata, 32'h0);
    chk32("rst_d_rdata",  bus.d_rdata,  32'h0);
    chk32("rst_mem_addr", bus.mem_addr, 32'h0);
    chk1 ("rst_err",      bus.err,      1'b0);

    // single fetch, ready in first busy cycle
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
    #1;
    serve(1'b0, 32'h40, 1'b0, 32'h0, MODE_WORD, 1, 32'h0050_0093, 1'b0);

    // simultaneous requests: data first, fetch after RESP + IDLE
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0044;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100; bus.d_mode = MODE_WORD;
    #1;
    serve(1'b1, 32'h100, 1'b0, bus.d_wdata, MODE_WORD, 2, 32'h1234_5678, 1'b0);
    next_cycle();
    #1;
    serve(1'b0, 32'h44, 1'b0, 32'h0, MODE_WORD, 1, 32'hCAFE_0001, 1'b0);

    // store with 5-cycle memory latency
    next_cycle();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_mode = MODE_BYTE;
    #1;
    serve(1'b1, 32'h200, 1'b1, 32'hDEAD_BEEF, MODE_BYTE, 5, 32'h5555_AAAA, 1'b0);

    // reset in the 2nd busy cycle of a fetch
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h80;
    #1;
    @(negedge clk); bus.mem_ready = 1'b0; #1;
    chk1("pre_rst_mem_req", bus.mem_req, 1'b1);
    @(negedge clk); bus.mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    m_if_rdata = '0; m_d_rdata = '0;
    chk1 ("midrst_mem_req",  bus.mem_req,  1'b0);
    chk1 ("midrst_stall",    bus.stall,    1'b0);
    chk1 ("midrst_if_valid", bus.if_valid, 1'b0);
    chk1 ("midrst_d_valid",  bus.d_valid,  1'b0);
    chk32("midrst_if_rdata", bus.if_rdata, 32'h0);
    chk32("midrst_d_rdata",  bus.d_rdata,  32'h0);
    bus.if_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      #1;
      chk1("postrst_if_valid", bus.if_valid, 1'b0);
      chk1("postrst_mem_req",  bus.mem_req,  1'b0);
    end
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h84;
    #1;
    serve(1'b0, 32'h84, 1'b0, 32'h0, MODE_WORD, 1, 32'h0000_0013, 1'b0);

    // request held through RESP is one new transaction
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h90;
    #1;
    serve(1'b0, 32'h90, 1'b0, 32'h0, MODE_WORD, 2, 32'h1111_2222, 1'b1);
    next_cycle();
    bus.if_addr = 32'h94;
    #1;
    serve(1'b0, 32'h94, 1'b0, 32'h0, MODE_WORD, 1, 32'h3333_4444, 1'b0);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      #1;
      chk1("held_after_mem_req",  bus.mem_req,  1'b0);
      chk1("held_after_if_valid", bus.if_valid, 1'b0);
      chk1("held_after_stall",    bus.stall,    1'b0);
    end

    // randomized traffic against the priority/latency model
    for (int t = 0; t < 30; t++) begin
      int unsigned mask;
      logic [31:0] fa, da, dw;
      logic        dwe;
      logic [2:0]  dm;
      mask = $urandom_range(1, 3);
      fa   = $urandom;
      da   = $urandom;
      dw   = $urandom;
      dwe  = 1'($urandom);
      dm   = modes[$urandom_range(0, 4)];
      next_cycle();
      bus.if_req = mask[0]; bus.if_addr = fa;
      bus.d_req  = mask[1]; bus.d_addr = da; bus.d_wdata = dw; bus.d_we = dwe; bus.d_mode = dm;
      #1;
      if (mask[1]) begin
        serve(1'b1, da, dwe, dw, dm, $urandom_range(1, 6), $urandom, 1'b0);
        if (mask[0]) begin
          next_cycle();
          #1;
        end
      end
      if (mask[0]) begin
        serve(1'b0, fa, 1'b0, 32'h0, MODE_WORD, $urandom_range(1, 6), $urandom, 1'b0);
      end
      next_cycle();
      #1;
      chk1("rand_idle_stall",   bus.stall,   1'b0);
      chk1("rand_idle_mem_req", bus.mem_req, 1'b0);
    end

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    // memory never answers: err and d_valid together, zero load data
    next_cycle();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300; bus.d_mode = MODE_WORD;
    bus.mem_ready = 1'b0;
    #1;
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk); bus.mem_ready = 1'b0; #1;
      chk1("to_mem_req", bus.mem_req, 1'b1);
      chk1("to_err_early", bus.err, 1'b0);
      chk1("to_valid_early", bus.d_valid, 1'b0);
    end
    @(negedge clk); bus.d_req = 1'b0; #1;
    m_d_rdata = '0;
    chk1 ("to_d_valid", bus.d_valid, 1'b1);
    chk1 ("to_err",     bus.err,     1'b1);
    chk32("to_d_rdata", bus.d_rdata, m_d_rdata);
    chk1 ("to_mem_req_off", bus.mem_req, 1'b0);
    next_cycle();
    #1;
    chk1("to_err_once", bus.err, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between two requesters: instruction fetch and load/store data access.
- Sits between the program counter / fetch path, the memory controller and the data path.
- Supports a variable-latency memory through a `mem_ready` handshake.
- Produces a `stall` that freezes the PC and register-file write while an access is outstanding.

Parameters:
- Width, 32, data and address width.
- TIMEOUT, 16, maximum number of busy cycles waited for `mem_ready`; used only with the optional feature.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high until `if_valid`.
- if_addr  in  Width  fetch address.
- if_valid  out  1  one-cycle pulse: `if_rdata` is valid.
- if_rdata  out  Width  fetched instruction.
- d_req  in  1  data request; held high until `d_valid`.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  Width  data address.
- d_wdata  in  Width  store data.
- d_mode  in  3  byte/half/word and signed/unsigned mode, same encoding as the memory controller Mode.
- d_valid  out  1  one-cycle pulse: data access complete.
- d_rdata  out  Width  load data.
- mem_req  out  1  request to memory; held until `mem_ready`.
- mem_we  out  1  write enable to memory.
- mem_addr  out  Width  address to memory.
- mem_wdata  out  Width  write data to memory.
- mem_mode  out  3  access mode to memory; fetch always uses word mode (3'b010).
- mem_ready  in  1  memory has completed the access this cycle.
- mem_rdata  in  Width  memory read data; valid when `mem_ready` is high.
- stall  out  1  core must hold PC and suppress writeback.
- err  out  1  one-cycle timeout pulse; only driven with the optional feature.

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_D, RESP.
- IDLE:
  - d_req → BUSY_D.
  - else if_req → BUSY_IF.
  - else stay in IDLE.
  - Data has fixed priority over fetch.
- On entering a BUSY state, latch address, wdata, we and mode into registers. `mem_*` outputs are driven from these registers, so requester inputs may change after the grant without effect.
- `mem_req` is high for the whole of BUSY_IF / BUSY_D.
- BUSY_x with mem_ready high:
  - capture `mem_rdata` into the matching rdata register;
  - deassert `mem_req` next cycle;
  - go to RESP.
- RESP:
  - exactly one of `if_valid` / `d_valid` is high for one cycle;
  - requests are ignored;
  - next state is IDLE.
- Requester handshake: the requester drops req in the RESP cycle. A req still high in the following IDLE cycle is treated as a new request.
- Latency:
  - grant edge at cycle 0;
  - `mem_req` high from cycle 1;
  - `mem_ready` in cycle k (k ≥ 1) → valid in cycle k+1;
  - back in IDLE at cycle k+2;
  - minimum req→valid latency is 2 cycles.
- Stores: `d_rdata` is unchanged; `d_valid` still pulses.
- `if_rdata` and `d_rdata` hold their last value until overwritten.
- stall (combinational):
  - 1 in BUSY_IF and BUSY_D;
  - 1 in IDLE when if_req or d_req is high;
  - 0 in RESP;
  - 0 in IDLE with no request.
- Simultaneous if_req and d_req in IDLE: data is served first, then fetch after the RESP/IDLE cycles.
- `mem_ready` high outside the BUSY states is ignored.
- Reset (asynchronous, at any time, including mid-transaction):
  - state → IDLE;
  - all outputs and registers → 0;
  - any in-flight access is discarded with no valid pulse.

Optional Feature:
- Macro: MEM_PORT_ARB_TIMEOUT_EN.
- Defined:
  - a busy-cycle counter resets on each grant and increments every BUSY cycle without `mem_ready`;
  - if the count reaches TIMEOUT−1 with `mem_ready` still low, the arbiter drops `mem_req` and enters RESP;
  - the matching valid pulses with rdata = 0, and `err` pulses in the same cycle.
- Undefined:
  - no counter is built;
  - `err` is tied to 0;
  - the arbiter waits for `mem_ready` indefinitely.

Decomposition:
- Shared package (`mem_port_pkg`):
  - state enum `arb_state_t` {IDLE, BUSY_IF, BUSY_D, RESP};
  - mode constants MODE_BYTE, MODE_HALF, MODE_WORD, MODE_BYTE_U, MODE_HALF_U.
- One natural sub-module: `arb_timeout_counter` (clear, enable, expired output), instantiated only under the macro.

Test Plan:
- if_req=1, if_addr=0x0000_0040; mem_ready high in first busy cycle with rdata=0x0050_0093 → `mem_addr`=0x40, `mem_mode`=3'b010; `if_valid` 2 cycles after grant with `if_rdata`=0x0050_0093; stall low in RESP.
- if_req and d_req both high in the same cycle (d_addr=0x100, load, word) → first `mem_addr`=0x100; `d_valid` before `if_valid`; fetch granted only after RESP+IDLE.
- Store d_we=1, d_addr=0x200, d_wdata=0xDEAD_BEEF, d_mode=3'b000; `mem_ready` delayed 5 cycles → `mem_req` high for 5 cycles with stable fields; one `d_valid`; `d_rdata` unchanged.
- Reset asserted in the 2nd busy cycle of a fetch → `mem_req`, stall and valids go to 0 immediately; no `if_valid` after release; next request starts from IDLE.
- req held high through RESP into IDLE → exactly one new transaction issued, with no duplicate valid in the RESP cycle.
- With MEM_PORT_ARB_TIMEOUT_EN and TIMEOUT=4, `mem_ready` never asserted → `err` and `d_valid` pulse together 4 cycles after `mem_req` rises; `d_rdata`=0.
